// File: rtl/draw_region_fsm.sv
//------------------------------------------------------------------------------
// draw_region_fsm
//
// Region redraw engine. A start request latches a rectangle (origin rx0/ry0,
// size rw x rh) and a map select. The rectangle is clipped to the visible
// screen. Its background pixels are then fetched from the background ROM in
// raster order, one address per clock. Each ROM result is forwarded to the VGA
// plot port once the ROM read latency has elapsed. After that, the plot port
// can optionally be handed to the sprite drawer so it re-overlays the
// character. done pulses once when everything is finished.
//
// Ports
//   clock, reset      system clock, asynchronous active-high reset
//   start             request, accepted only while idle (level sensitive)
//   gameState         map select, latched on accept, presented on rom_state
//   rx0, ry0, rw, rh  region origin and size, latched on accept
//   char_en           redraw the character after the background
//   rom_state/x/y     background ROM address
//   rom_color         ROM data, valid ROM_LAT cycles after its address
//   char_start        one-cycle kick to the sprite drawer
//   char_done         sprite drawer finished
//   char_plot/x/y/color  sprite drawer plot port, forwarded while it owns VGA
//   vga_plot/x/y/color   plot port toward the frame buffer
//   busy              high whenever not idle
//   done              one-cycle completion pulse
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module draw_region_fsm #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COLOR_W  = 3,
  parameter int STATE_W  = 4,
  parameter int ROM_LAT  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] gameState,
  input  logic [X_W-1:0]     rx0,
  input  logic [Y_W-1:0]     ry0,
  input  logic [X_W-1:0]     rw,
  input  logic [Y_W-1:0]     rh,
  input  logic               char_en,
  output logic [STATE_W-1:0] rom_state,
  output logic [X_W-1:0]     rom_x,
  output logic [Y_W-1:0]     rom_y,
  input  logic [COLOR_W-1:0] rom_color,
  output logic               char_start,
  input  logic               char_done,
  input  logic               char_plot,
  input  logic [X_W-1:0]     char_x,
  input  logic [Y_W-1:0]     char_y,
  input  logic [COLOR_W-1:0] char_color,
  output logic               vga_plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               busy,
  output logic               done
);

  // Screen limits widened by one bit so the origin+size sums can be compared
  // against them without wrap-around.
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  typedef enum logic [2:0] {
    IDLE, LATCH, STREAM, DRAIN, CHAR_CHK, CHAR_START, CHAR_WAIT, DONE
  } state_t;

  state_t state;

  // Latched request
  logic [X_W-1:0] req_x0, req_w;
  logic [Y_W-1:0] req_y0, req_h;
  logic           req_char;

  // Clipped inclusive end coordinates and the raster scan counters
  logic [X_W-1:0] x_end, cnt_x;
  logic [Y_W-1:0] y_end, cnt_y;

  //----------------------------------------------------------------------------
  // Clipping, evaluated from the latched request during LATCH
  //----------------------------------------------------------------------------
  logic [X_W:0] x_sum, x_lim;
  logic [Y_W:0] y_sum, y_lim;
  logic         region_empty;

  always_comb begin
    x_sum = {1'b0, req_x0} + {1'b0, req_w};
    y_sum = {1'b0, req_y0} + {1'b0, req_h};
    x_lim = (x_sum > SCR_W) ? SCR_W : x_sum;
    y_lim = (y_sum > SCR_H) ? SCR_H : y_sum;
    // An origin off-screen, or a zero dimension, yields nothing to draw; this
    // also guarantees x_lim/y_lim are non-zero whenever they are used.
    region_empty = (req_w == '0) || (req_h == '0) ||
                   ({1'b0, req_x0} >= SCR_W) || ({1'b0, req_y0} >= SCR_H);
  end

  assign rom_x = cnt_x;
  assign rom_y = cnt_y;

  //----------------------------------------------------------------------------
  // Control FSM
  //----------------------------------------------------------------------------
  logic pipe_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_x0     <= '0;
      req_y0     <= '0;
      req_w      <= '0;
      req_h      <= '0;
      req_char   <= 1'b0;
      rom_state  <= '0;
      x_end      <= '0;
      y_end      <= '0;
      cnt_x      <= '0;
      cnt_y      <= '0;
      char_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Pulsed outputs are raised on the transition into their state only.
      char_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req_x0    <= rx0;
            req_y0    <= ry0;
            req_w     <= rw;
            req_h     <= rh;
            req_char  <= char_en;
            rom_state <= gameState;
            busy      <= 1'b1;
            state     <= LATCH;
          end
        end
        LATCH: begin
          x_end <= X_W'(x_lim - 1'b1);
          y_end <= Y_W'(y_lim - 1'b1);
          if (region_empty) begin
            state <= CHAR_CHK;
          end else begin
            cnt_x <= req_x0;
            cnt_y <= req_y0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (cnt_x == x_end) begin
            cnt_x <= req_x0;
            if (cnt_y == y_end) state <= DRAIN;
            else                cnt_y <= cnt_y + 1'b1;
          end else begin
            cnt_x <= cnt_x + 1'b1;
          end
        end
        DRAIN: begin
          if (!pipe_busy) state <= CHAR_CHK;
        end
        CHAR_CHK: begin
          if (req_char) begin
            char_start <= 1'b1;
            state      <= CHAR_START;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        CHAR_START: state <= CHAR_WAIT;
        CHAR_WAIT: begin
          if (char_done) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // ROM latency pipeline: an address issued in STREAM reaches stage ROM_LAT
  // in the same cycle as its ROM data, which is then registered onto VGA.
  //----------------------------------------------------------------------------
  logic [ROM_LAT:1]          vld_pipe;
  logic [ROM_LAT:1][X_W-1:0] x_pipe;
  logic [ROM_LAT:1][Y_W-1:0] y_pipe;

  logic               bg_plot;
  logic [X_W-1:0]     bg_x;
  logic [Y_W-1:0]     bg_y;
  logic [COLOR_W-1:0] bg_color;

  assign pipe_busy = |vld_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      x_pipe   <= '0;
      y_pipe   <= '0;
      bg_plot  <= 1'b0;
      bg_x     <= '0;
      bg_y     <= '0;
      bg_color <= '0;
    end else begin
      vld_pipe[1] <= (state == STREAM);
      x_pipe[1]   <= cnt_x;
      y_pipe[1]   <= cnt_y;
      for (int i = 2; i <= ROM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        x_pipe[i]   <= x_pipe[i-1];
        y_pipe[i]   <= y_pipe[i-1];
      end
      // Idle cycles drive zeros so the plot port is quiet between pixels.
      bg_plot  <= vld_pipe[ROM_LAT];
      bg_x     <= vld_pipe[ROM_LAT] ? x_pipe[ROM_LAT] : '0;
      bg_y     <= vld_pipe[ROM_LAT] ? y_pipe[ROM_LAT] : '0;
      bg_color <= vld_pipe[ROM_LAT] ? rom_color : '0;
    end
  end

  //----------------------------------------------------------------------------
  // Plot port ownership: the sprite drawer owns VGA only in CHAR_WAIT. The
  // background registers are idle (zero) by then since DRAIN emptied them.
  //----------------------------------------------------------------------------
  always_comb begin
    vga_plot  = bg_plot;
    vga_x     = bg_x;
    vga_y     = bg_y;
    vga_color = bg_color;
    if (state == CHAR_WAIT) begin
      vga_plot  = char_plot;
      vga_x     = char_x;
      vga_y     = char_y;
      vga_color = char_color;
    end
  end

endmodule

// File: doc/draw_region_fsm.md
Name: draw_region_fsm

Overview:
- Parametrised redraw engine for rectangular screen regions.
- On a start request it streams the background pixels of one rectangle from the background ROM to the VGA plot port, one pixel per clock, with a configurable ROM read latency.
- It then optionally hands the plot port to the sprite drawer to re-overlay the character.
- It replaces the full-screen redraw with a clipped, pipelined, region-only redraw used for per-move updates.

Parameters:
- X_W, 9, width of X coordinates.
- Y_W, 8, width of Y coordinates.
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- COLOR_W, 3, colour width.
- STATE_W, 4, gameState width.
- ROM_LAT, 1, background ROM read latency in cycles (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- gameState  in  STATE_W  map select; latched on accept.
- rx0  in  X_W  region origin X; latched on accept.
- ry0  in  Y_W  region origin Y; latched on accept.
- rw  in  X_W  region width; latched on accept.
- rh  in  Y_W  region height; latched on accept.
- char_en  in  1  redraw character after background; latched on accept.
- rom_state  out  STATE_W  latched gameState to ROM.
- rom_x  out  X_W  ROM pixel address X.
- rom_y  out  Y_W  ROM pixel address Y.
- rom_color  in  COLOR_W  ROM data, valid ROM_LAT cycles after address.
- char_start  out  1  one-cycle pulse to sprite drawer.
- char_done  in  1  sprite drawer finished.
- char_plot  in  1  sprite drawer plot strobe.
- char_x  in  X_W  sprite drawer X.
- char_y  in  Y_W  sprite drawer Y.
- char_color  in  COLOR_W  sprite drawer colour.
- vga_plot  out  1  plot strobe.
- vga_x  out  X_W  plot X.
- vga_y  out  Y_W  plot Y.
- vga_color  out  COLOR_W  plot colour.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; pipeline valid bits cleared.
  - All outputs 0: vga_*, rom_*, char_start, busy, done.
- States:
  - IDLE: start=1 -> LATCH; latch all request inputs.
- LATCH:
  - Compute x_end = min(rx0+rw, SCREEN_W)-1 and y_end = min(ry0+rh, SCREEN_H)-1.
  - Use X_W+1 / Y_W+1 bit arithmetic, so there is no wrap-around.
  - Region is empty if rw==0, rh==0, rx0>=SCREEN_W or ry0>=SCREEN_H.
  - Empty -> CHAR_CHK; else load counters to (rx0, ry0) -> STREAM.
- STREAM:
  - Each cycle, drive rom_x/rom_y from the counters and push valid plus (x,y) into a ROM_LAT-deep shift register.
  - Scan is raster order: x increments; at x_end, x returns to rx0 and y increments.
  - After issuing (x_end, y_end) -> DRAIN.
- Output timing:
  - Address issued in cycle t produces vga_plot=1 with the matching x, y and rom_color in cycle t+ROM_LAT+1 (registered outputs).
  - vga_plot=0 otherwise.
- DRAIN: wait until the shift register is empty -> CHAR_CHK.
- CHAR_CHK: char_en=1 -> CHAR_START; else -> DONE.
- CHAR_START:
  - Assert char_start for exactly one cycle -> CHAR_WAIT.
- CHAR_WAIT:
  - vga_plot/x/y/color are driven combinationally from the char_* inputs.
  - char_done=1 -> DONE. No timeout.
- DONE: done=1 for one cycle -> IDLE.
- A clipped region of W' x H' pixels gives exactly W'*H' plots: no duplicates, none off-screen.
- start while busy is ignored. It is not queued and the latched request is unchanged.
- start held high across DONE -> IDLE starts a new redraw (level-sensitive accept).
- char_plot outside CHAR_WAIT is ignored.
- Reset mid-operation:
  - Immediate abort; in-flight pixels are discarded.
  - No done and no char_start pulse afterwards.

Test Plan:
- ROM model color = (x+y)[2:0], ROM_LAT=1, region (10,5) size 4x2, char_en=0:
  - exactly 8 plots in order (10,5)..(13,5),(10,6)..(13,6), colours match the model.
  - First plot 2 cycles after the first address; done pulses once; busy low the cycle after done.
- Region (318,238) size 5x5:
  - exactly 4 plots at (318,238),(319,238),(318,239),(319,239), then done.
- rw=0, char_en=1:
  - no background plots; one char_start pulse.
  - Sprite model plots (50,60) colour 5 and then raises char_done -> vga output (50,60,5), then done.
- ROM_LAT=3, region (0,0) size 3x1:
  - plots appear 4 cycles after their addresses; DRAIN holds until the third plot; done follows.
- start pulsed again mid-STREAM with a different region:
  - ignored; original plot sequence unchanged.
- reset asserted mid-STREAM:
  - all outputs 0 asynchronously; no further plots, done or char_start.
  - A subsequent start redraws correctly from the new origin.
